// File: rtl/mem_responder.sv
// mem_responder: byte-serial, little-endian responder between the MEM-stage
// request interface and a byte-wide synchronous RAM. Every output is registered.
// Optional build macro: MEM_BOUND_CHECK_EN. When it is defined, out-of-range
// requests complete at once with mem_err set. When it is not defined, the upper
// address bits are ignored and byte addresses wrap.
//
// state | meaning
// IDLE  | waiting; request strobes are sampled on every edge
// RD    | reading 4 bytes; ram_rdata lags ram_addr by one cycle
// WR    | writing 1/2/4 bytes, one per cycle
// DONE  | single completion cycle; request strobes are not sampled

module mem_responder #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_write_type,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_data,
    output logic              mem_done,
    output logic              mem_busy,
    output logic              mem_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wr,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [2:0]        nbytes, nbytes_nxt;
    logic [23:0]       wdata_q, wdata_nxt;
    logic [31:0]       data_nxt;
    logic              done_nxt, busy_nxt, err_nxt, wr_nxt;
    logic [ADDR_W-1:0] raddr_nxt;
    logic [7:0]        rwdata_nxt;
    logic [2:0]        req_bytes;
    logic              oob;

    // Number of bytes the request on the inputs would move (reads are always 4).
    always_comb begin
        req_bytes = 3'd4;
        if (mem_write) begin
            case (mem_write_type)
                2'd1:    req_bytes = 3'd1;
                2'd2:    req_bytes = 3'd2;
                2'd3:    req_bytes = 3'd4;
                default: req_bytes = 3'd0;
            endcase
        end
    end

`ifdef MEM_BOUND_CHECK_EN
    logic [ADDR_W:0] last_addr;

    // Reject the request if the upper address bits are set, or if its last byte falls past the top of the RAM.
    always_comb begin
        last_addr = {1'b0, mem_addr[ADDR_W-1:0]} + {{(ADDR_W-2){1'b0}}, req_bytes - 3'd1};
        oob       = (|mem_addr[31:ADDR_W]) || ((req_bytes != 3'd0) && last_addr[ADDR_W]);
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:ADDR_W];
    assign oob            = 1'b0;
`endif

    // Next-state and next-output logic; every output register is loaded from here.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        nbytes_nxt = nbytes;
        wdata_nxt  = wdata_q;
        data_nxt   = mem_data;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        wr_nxt     = 1'b0;
        raddr_nxt  = ram_addr;
        rwdata_nxt = ram_wdata;
        unique case (state)
            IDLE: begin
                if (mem_write || mem_read) begin
                    cnt_nxt    = 3'd0;
                    nbytes_nxt = req_bytes;
                    wdata_nxt  = mem_wdata[31:8];
                    raddr_nxt  = mem_addr[ADDR_W-1:0];
                    rwdata_nxt = mem_wdata[7:0];
                    if (oob) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                        err_nxt   = 1'b1;
                        if (!mem_write) data_nxt = '0;
                    end else if (mem_write && (req_bytes == 3'd0)) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else if (mem_write) begin
                        state_nxt = WR;
                        wr_nxt    = 1'b1;
                    end else begin
                        state_nxt = RD;
                    end
                end
            end
            RD: begin
                cnt_nxt = cnt + 3'd1;
                // The byte returned now is the one addressed in the previous cycle.
                case (cnt)
                    3'd1:    data_nxt[7:0]   = ram_rdata;
                    3'd2:    data_nxt[15:8]  = ram_rdata;
                    3'd3:    data_nxt[23:16] = ram_rdata;
                    3'd4:    data_nxt[31:24] = ram_rdata;
                    default: ;
                endcase
                if (cnt < 3'd3) raddr_nxt = ram_addr + ADDR_ONE;
                if (cnt == 3'd4) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            WR: begin
                if (cnt + 3'd1 == nbytes) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt    = cnt + 3'd1;
                    wr_nxt     = 1'b1;
                    raddr_nxt  = ram_addr + ADDR_ONE;
                    rwdata_nxt = wdata_q[7:0];
                    wdata_nxt  = {8'h00, wdata_q[23:8]};
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers, cleared by a synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            nbytes    <= 3'd0;
            wdata_q   <= '0;
            mem_data  <= '0;
            mem_done  <= 1'b0;
            mem_busy  <= 1'b0;
            mem_err   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wr    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            nbytes    <= nbytes_nxt;
            wdata_q   <= wdata_nxt;
            mem_data  <= data_nxt;
            mem_done  <= done_nxt;
            mem_busy  <= busy_nxt;
            mem_err   <= err_nxt;
            ram_addr  <= raddr_nxt;
            ram_wdata <= rwdata_nxt;
            ram_wr    <= wr_nxt;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder. The bench builds a queue of expected outputs, one
// entry per cycle. It derives each entry from the request schedule and from a
// byte-array model of the RAM. It also checks some fixed literal values.

module tb_mem_responder;

    localparam int AW    = 17;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [1:0]    mem_write_type = 2'd0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic [31:0]   mem_data;
    logic          mem_done, mem_busy, mem_err, ram_wr;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;

    logic [7:0]    ram [DEPTH];
    logic [7:0]    mdl [DEPTH];

    typedef struct packed {
        logic          busy, done, err, wr, chk_a, chk_w;
        logic [AW-1:0] a;
        logic [7:0]    w;
        logic [31:0]   d;
    } exp_t;

    exp_t        q[$];
    logic [31:0] cur_data = '0;
    int          total = 0;
    int          bad = 0;

    mem_responder #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_write_type(mem_write_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_data(mem_data), .mem_done(mem_done), .mem_busy(mem_busy), .mem_err(mem_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr(ram_wr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("mem_busy", 32'(mem_busy), 32'(e.busy));
            chk("mem_done", 32'(mem_done), 32'(e.done));
            chk("mem_err", 32'(mem_err), 32'(e.err));
            chk("ram_wr", 32'(ram_wr), 32'(e.wr));
            if (e.chk_a) chk("ram_addr", 32'(ram_addr), 32'(e.a));
            if (e.chk_w) chk("ram_wdata", 32'(ram_wdata), 32'(e.w));
            chk("mem_data", mem_data, e.d);
        end
    end

    function automatic exp_t idle_exp();
        exp_t e;
        e   = '0;
        e.d = cur_data;
        return e;
    endfunction

    function automatic int nb_of(input logic [1:0] t);
        case (t)
            2'd1:    return 1;
            2'd2:    return 2;
            2'd3:    return 4;
            default: return 0;
        endcase
    endfunction

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            next_cyc();
            q.push_back(idle_exp());
        end
    endtask

    task automatic scramble();
        mem_addr       = $urandom;
        mem_wdata      = $urandom;
        mem_write_type = 2'($urandom);
    endtask

    // Present a request in the current idle cycle. Push the expected outputs for
    // every cycle up to and including the done cycle, then drop the strobes.
    task automatic do_req(input logic rd, input logic wr, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] d);
        int            nb;
        bit            oob;
        logic [AW-1:0] b;
        logic [31:0]   old, nw;
        exp_t          e;
        nb  = wr ? nb_of(t) : 4;
        oob = 1'b0;
        b   = a[AW-1:0];
`ifdef MEM_BOUND_CHECK_EN
        oob = (a[31:AW] != 0) || (nb != 0 && (int'(b) + nb - 1 >= DEPTH));
`endif
        mem_read = rd; mem_write = wr; mem_write_type = t; mem_addr = a; mem_wdata = d;
        if (oob || (wr && nb == 0)) begin
            next_cyc(); scramble();
            if (oob && !wr) cur_data = '0;
            e = idle_exp(); e.busy = 1'b1; e.done = 1'b1; e.err = oob;
            q.push_back(e);
        end else if (wr) begin
            for (int k = 0; k < nb; k++) begin
                next_cyc(); scramble();
                e = idle_exp(); e.busy = 1'b1; e.wr = 1'b1; e.chk_a = 1'b1; e.chk_w = 1'b1;
                e.a = b + AW'(k);
                e.w = d[8*k +: 8];
                mdl[e.a] = e.w;
                q.push_back(e);
            end
            next_cyc();
            e = idle_exp(); e.busy = 1'b1; e.done = 1'b1;
            q.push_back(e);
        end else begin
            old = cur_data;
            for (int j = 0; j < 4; j++) nw[8*j +: 8] = mdl[b + AW'(j)];
            for (int c = 0; c <= 5; c++) begin
                next_cyc(); scramble();
                e = idle_exp(); e.busy = 1'b1; e.done = (c == 5);
                e.chk_a = (c <= 3); e.a = b + AW'(c);
                for (int j = 0; j < 4; j++) e.d[8*j +: 8] = (j <= c - 2) ? nw[8*j +: 8] : old[8*j +: 8];
                q.push_back(e);
            end
            cur_data = nw;
        end
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        exp_t        e;
        logic [7:0]  v;
        logic [31:0] ra;
        logic [7:0]  saved;
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'($urandom); ram[i] = v; mdl[i] = v;
        end
        ram[32'h10] = 8'h78; ram[32'h11] = 8'h56; ram[32'h12] = 8'h34; ram[32'h13] = 8'h12;
        mdl[32'h10] = 8'h78; mdl[32'h11] = 8'h56; mdl[32'h12] = 8'h34; mdl[32'h13] = 8'h12;
        for (int i = 32'h40; i < 32'h44; i++) begin ram[i] = 8'h00; mdl[i] = 8'h00; end

        rst = 1'b0;
        next_cyc();
        e = '0; e.chk_a = 1'b1; e.chk_w = 1'b1; q.push_back(e);
        chk("reset_ram_addr", 32'(ram_addr), 32'h0);
        next_cyc();
        q.push_back(e);
        rst = 1'b1;
        idle(2);

        do_req(1'b1, 1'b0, 2'd0, 32'h10, 32'h0);
        chk("read_0x10", mem_data, 32'h12345678);
        chk("model_read_0x10", cur_data, 32'h12345678);
        idle(1);

        do_req(1'b0, 1'b1, 2'd3, 32'h20, 32'hDEADBEEF);
        idle(1);
        chk("sw_byte0", 32'(ram[32'h20]), 32'hEF);
        chk("sw_byte3", 32'(ram[32'h23]), 32'hDE);
        do_req(1'b1, 1'b0, 2'd0, 32'h20, 32'h0);
        chk("readback_sw", mem_data, 32'hDEADBEEF);
        idle(1);

        do_req(1'b0, 1'b1, 2'd1, 32'h20, 32'h000000AA);
        idle(1);
        do_req(1'b0, 1'b1, 2'd2, 32'h20, 32'h0000BBCC);
        idle(1);
        do_req(1'b1, 1'b0, 2'd0, 32'h20, 32'h0);
        chk("readback_sb_sh", mem_data, 32'hDEADBBCC);
        idle(1);

        do_req(1'b1, 1'b1, 2'd3, 32'h30, 32'h11223344);
        chk("both_strobes_data", mem_data, 32'hDEADBBCC);
        idle(1);
        chk("both_strobes_b0", 32'(ram[32'h30]), 32'h44);
        chk("both_strobes_b3", 32'(ram[32'h33]), 32'h11);

`ifndef MEM_BOUND_CHECK_EN
        do_req(1'b0, 1'b1, 2'd3, 32'h1FFFF, 32'hA1B2C3D4);
        idle(1);
        chk("wrap_1ffff", 32'(ram[32'h1FFFF]), 32'hD4);
        chk("wrap_0", 32'(ram[32'h0]), 32'hC3);
        chk("wrap_1", 32'(ram[32'h1]), 32'hB2);
        chk("wrap_2", 32'(ram[32'h2]), 32'hA1);
        do_req(1'b1, 1'b0, 2'd0, 32'h1FFFF, 32'h0);
        chk("wrap_read", mem_data, 32'hA1B2C3D4);
        idle(1);
`else
        saved = ram[32'h1FFFF];
        do_req(1'b0, 1'b1, 2'd3, 32'h1FFFF, 32'hA1B2C3D4);
        chk("oob_write_err", 32'(mem_err), 32'h1);
        idle(1);
        chk("oob_write_untouched", 32'(ram[32'h1FFFF]), 32'(saved));
        do_req(1'b1, 1'b0, 2'd0, 32'h00020000, 32'h0);
        chk("oob_read_err", 32'(mem_err), 32'h1);
        chk("oob_read_done", 32'(mem_done), 32'h1);
        chk("oob_read_data", mem_data, 32'h0);
        idle(1);
`endif

        // Reset is sampled low at the edge that begins cycle 2 of a store word.
        mem_write = 1'b1; mem_write_type = 2'd3; mem_addr = 32'h40; mem_wdata = 32'h55667788;
        next_cyc();
        e = idle_exp(); e.busy = 1'b1; e.wr = 1'b1; e.chk_a = 1'b1; e.chk_w = 1'b1;
        e.a = AW'(32'h40); e.w = 8'h88; mdl[32'h40] = 8'h88; q.push_back(e);
        next_cyc();
        e.a = AW'(32'h41); e.w = 8'h77; mdl[32'h41] = 8'h77; q.push_back(e);
        rst = 1'b0;
        next_cyc();
        cur_data = '0;
        e = '0; e.chk_a = 1'b1; e.chk_w = 1'b1; q.push_back(e);
        rst = 1'b1; mem_write = 1'b0;
        idle(2);
        chk("rst_mid_b1", 32'(ram[32'h41]), 32'h77);
        chk("rst_mid_b2", 32'(ram[32'h42]), 32'h00);
        do_req(1'b1, 1'b0, 2'd0, 32'h40, 32'h0);
        chk("rst_mid_readback", mem_data, 32'h00007788);
        idle(1);

        for (int n = 0; n < 60; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? (32'h1FFF0 + $urandom_range(0, 15)) : $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) ra[31:AW] = 15'($urandom_range(1, 32767));
            case ($urandom_range(0, 2))
                0:       do_req(1'b1, 1'b0, 2'($urandom), ra, $urandom);
                1:       do_req(1'b0, 1'b1, 2'($urandom), ra, $urandom);
                default: do_req(1'b1, 1'b1, 2'($urandom), ra, $urandom);
            endcase
            idle($urandom_range(1, 3));
        end

        idle(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder to the MEM stage's request interface (read/write strobes, 32-bit address and write data, store width).
- Serves each accepted request over a byte-wide synchronous RAM port, byte-serial and little-endian.
- Returns a 32-bit read word plus a one-cycle completion pulse.
- Drives a busy level that the hazard/stall logic uses to freeze the pipeline.

Parameters:
- ADDR_W, 17, RAM byte-address width; RAM depth is 2^ADDR_W bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst==0 sampled at a rising edge resets the block)
- mem_read  in  1  read request; always returns a full 32-bit word
- mem_write  in  1  write request
- mem_write_type  in  2  0=No_mem_write, 1=sb, 2=sh, 3=sw
- mem_addr  in  32  byte address of the request
- mem_wdata  in  32  store data; low 1/2/4 bytes used according to type
- mem_data  out  32  last completed read word
- mem_done  out  1  one-cycle completion pulse
- mem_busy  out  1  request in progress; stalls the pipeline
- mem_err  out  1  out-of-range flag; tied 0 unless feature enabled
- ram_addr  out  ADDR_W  RAM byte address
- ram_wdata  out  8  RAM write byte
- ram_wr  out  1  RAM write enable
- ram_rdata  in  8  RAM read byte, valid one cycle after ram_addr is presented

Behaviour:
- All outputs registered.
- Reset values: all outputs 0, state IDLE, byte counter 0.
- States: IDLE, RD, WR, DONE.
- IDLE: request sampled at an edge E0 = accept.
  - mem_write=1 → WR (write has priority when both strobes are 1).
  - Otherwise mem_read=1 → RD.
  - Address, data and type latched at E0; later input changes are ignored until the next IDLE.
  - Write with type 0 → DONE directly, no RAM access.
- Cycle k = interval from Ek to Ek+1. Byte address = latched mem_addr + k, truncated to ADDR_W (wraps modulo 2^ADDR_W).
- RD:
  - ram_addr = addr+k during cycles 0..3; ram_wr=0.
  - Byte k is captured at edge Ek+2 into mem_data[8k+7:8k].
  - mem_done is high in cycle 5 only; mem_data is stable from cycle 5 until the next read completes.
- WR (N = 1/2/4 for sb/sh/sw):
  - ram_wr=1, ram_addr=addr+k, ram_wdata=mem_wdata[8k+7:8k] in cycles 0..N-1.
  - mem_done is high in cycle N; ram_wr=0 from cycle N.
  - mem_data is unchanged by writes.
- DONE:
  - Lasts exactly one cycle with mem_done=1, then returns to IDLE.
  - Requests present during DONE are not sampled.
  - The first new accept can occur at the edge ending the first IDLE cycle after DONE.
- mem_busy = (state != IDLE): high from cycle 0 through the done cycle inclusive.
- Back-to-back: the initiator holds its request until it sees mem_done. The next request is accepted no earlier than 2 edges after the done cycle begins.
- Reset mid-operation:
  - Next edge with rst=0 forces IDLE and clears all outputs (including mem_data) in the following cycle.
  - Bytes already written stay in RAM; no completion pulse is issued.

Optional Feature:
- Macro MEM_BOUND_CHECK_EN.
- Defined: at accept, if mem_addr[31:ADDR_W] != 0 or (addr + bytes - 1) exceeds 2^ADDR_W - 1, the block goes directly to DONE.
  - No RAM access and ram_wr stays 0.
  - mem_err=1 together with mem_done for that one cycle.
  - For reads, mem_data is set to 0.
- Undefined: upper address bits are ignored, byte addresses wrap, and mem_err is constant 0.

Test Plan:
- Preload RAM[0x10..0x13]=78,56,34,12; mem_read, addr 0x10 → mem_busy cycles 0..5, mem_done only in cycle 5, mem_data=0x12345678.
- sw addr 0x20, data 0xDEADBEEF → ram_wr in cycles 0..3 with bytes EF,BE,AD,DE; done in cycle 4; read-back = 0xDEADBEEF.
- sb then sh to 0x20 with data 0x000000AA and 0x0000BBCC → done at cycle 1 and cycle 2 respectively; read of 0x20 returns 0xDEADBBCC.
- mem_read and mem_write both high, sw addr 0x30, data 0x11223344 → write performed, mem_data unchanged; addr 0x1FFFF with ADDR_W=17 and feature off → bytes at 0x1FFFF,0x0,0x1,0x2.
- rst=0 asserted in cycle 2 of an sw to 0x40 → next cycle all outputs 0 and IDLE, no done pulse; RAM holds the first 2 bytes only.
- With MEM_BOUND_CHECK_EN, read addr 0x00020000 → done and mem_err in cycle 0-equivalent DONE cycle, ram_wr never high, mem_data=0.
